// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types and constants for the ID/EX operand stage.
// ALU op codes, forwarding selects and the ID/EX register bundle.
package id_ex_operand_stage_pkg;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  localparam logic [CW-1:0] ALU_AND  = 4'b0000;
  localparam logic [CW-1:0] ALU_OR   = 4'b0001;
  localparam logic [CW-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CW-1:0] ALU_XOR  = 4'b0011;
  localparam logic [CW-1:0] ALU_NOR  = 4'b0100;
  localparam logic [CW-1:0] ALU_SLL  = 4'b0101;
  localparam logic [CW-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CW-1:0] ALU_LUI  = 4'b0111;
  localparam logic [CW-1:0] ALU_SLTU = 4'b1000;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_to_reg;
    logic          mem_write;
    logic [CW-1:0] alu_ctrl;
    logic          alu_src;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] write_reg;
    logic [15:0]   imm;
    logic [DW-1:0] imm32;
  } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// RAW forwarding for one EX source operand.
// MEM result beats WB result; register 0 is never forwarded.
module fwd_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_val,
  input  logic [DW-1:0] alu_out_m,
  input  logic [RW-1:0] write_reg_m,
  input  logic          reg_write_m,
  input  logic [DW-1:0] result_w,
  input  logic [RW-1:0] write_reg_w,
  input  logic          reg_write_w,
  output logic [DW-1:0] val
);

  logic [1:0] sel;

  always_comb begin
    sel = FWD_REG;
    if (reg_write_m && write_reg_m != '0 && write_reg_m == idx)
      sel = FWD_MEM;
    else if (reg_write_w && write_reg_w != '0 && write_reg_w == idx)
      sel = FWD_WB;
  end

  always_comb begin
    val = reg_val;
    unique case (sel)
      FWD_MEM: val = alu_out_m;
      FWD_WB:  val = result_w;
      default: val = reg_val;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX operand selection.
// Honours hazard-unit flush (bubble) and stall (hold).
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          StallE,
  input  logic          FlushE,
  input  logic          ValidD,
  input  logic [DW-1:0] RD1D,
  input  logic [DW-1:0] RD2D,
  input  logic [RW-1:0] RsD,
  input  logic [RW-1:0] RtD,
  input  logic [RW-1:0] RdD,
  input  logic [15:0]   ImmD,
  input  logic [CW-1:0] ALUCtrlD,
  input  logic          ALUSrcD,
  input  logic          ZeroExtD,
  input  logic          RegDstD,
  input  logic          RegWriteD,
  input  logic          MemtoRegD,
  input  logic          MemWriteD,
  input  logic [DW-1:0] ALUOutM,
  input  logic [RW-1:0] WriteRegM,
  input  logic          RegWriteM,
  input  logic [DW-1:0] ResultW,
  input  logic [RW-1:0] WriteRegW,
  input  logic          RegWriteW,
  output logic [DW-1:0] SrcAE,
  output logic [DW-1:0] SrcBE,
  output logic [CW-1:0] ALUCtrlE,
  output logic [DW-1:0] WriteDataE,
  output logic [RW-1:0] WriteRegE,
  output logic          RegWriteE,
  output logic          MemtoRegE,
  output logic          MemWriteE,
  output logic          ValidE,
  output logic [RW-1:0] RsE,
  output logic [RW-1:0] RtE
);

  id_ex_t e_q;
  id_ex_t d_in;
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  always_comb begin
    d_in            = '0;
    d_in.valid      = ValidD;
    d_in.reg_write  = RegWriteD;
    d_in.mem_to_reg = MemtoRegD;
    d_in.mem_write  = MemWriteD;
    d_in.alu_ctrl   = ALUCtrlD;
    d_in.alu_src    = ALUSrcD;
    d_in.rd1        = RD1D;
    d_in.rd2        = RD2D;
    d_in.rs         = RsD;
    d_in.rt         = RtD;
    d_in.write_reg  = RegDstD ? RdD : RtD;
    d_in.imm        = ImmD;
    d_in.imm32      = ZeroExtD ? {16'h0, ImmD}
                               : {{16{ImmD[15]}}, ImmD};
  end

  // Flush only clears control; data fields are don't-care in a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= '0;
    end else if (FlushE) begin
      e_q.valid      <= 1'b0;
      e_q.reg_write  <= 1'b0;
      e_q.mem_to_reg <= 1'b0;
      e_q.mem_write  <= 1'b0;
      e_q.alu_ctrl   <= '0;
    end else if (!StallE) begin
      e_q <= d_in;
    end
  end

  fwd_mux u_fwd_a (
    .idx         (e_q.rs),
    .reg_val     (e_q.rd1),
    .alu_out_m   (ALUOutM),
    .write_reg_m (WriteRegM),
    .reg_write_m (RegWriteM),
    .result_w    (ResultW),
    .write_reg_w (WriteRegW),
    .reg_write_w (RegWriteW),
    .val         (fwd_a)
  );

  fwd_mux u_fwd_b (
    .idx         (e_q.rt),
    .reg_val     (e_q.rd2),
    .alu_out_m   (ALUOutM),
    .write_reg_m (WriteRegM),
    .reg_write_m (RegWriteM),
    .result_w    (ResultW),
    .write_reg_w (WriteRegW),
    .reg_write_w (RegWriteW),
    .val         (fwd_b)
  );

  assign SrcAE = (e_q.alu_ctrl == ALU_LUI) ? {e_q.imm, 16'h0}
                                           : fwd_a;
  assign SrcBE      = e_q.alu_src ? e_q.imm32 : fwd_b;
  assign WriteDataE = fwd_b;
  assign ALUCtrlE   = e_q.alu_ctrl;
  assign WriteRegE  = e_q.write_reg;
  assign RegWriteE  = e_q.reg_write;
  assign MemtoRegE  = e_q.mem_to_reg;
  assign MemWriteE  = e_q.mem_write;
  assign ValidE     = e_q.valid;
  assign RsE        = e_q.rs;
  assign RtE        = e_q.rt;

endmodule
